// File: rtl/sn74ls_dff_bank_if.sv
// Pin bundle for sn74ls_dff_bank: chip-side clock/data/preset/clear inputs
// and the registered q/qn/cap outputs.
interface sn74ls_dff_bank_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 1
);
  logic [CHANNELS-1:0]       tclk;
  logic [CHANNELS*WIDTH-1:0] d;
  logic [CHANNELS-1:0]       prn;
  logic [CHANNELS-1:0]       clrn;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS*WIDTH-1:0] qn;
  logic [CHANNELS-1:0]       cap;

  modport master (output tclk, d, prn, clrn, input q, qn, cap);
  modport slave  (input tclk, d, prn, clrn, output q, qn, cap);
endinterface

// File: rtl/sn74ls_dff_bank.sv
// Bank of 74LS74-style D registers whose chip clocks are sampled as data and edge-detected
// on clk. Optional macro SN74LS_DFF_BOTH_ACTIVE_EN models the clear+preset both-high quirk.
module sn74ls_dff_bank #(
  parameter int CHANNELS     = 2,
  parameter int WIDTH        = 1,
  parameter int SYNC_STAGES  = 0,
  parameter int FALLING_EDGE = 0
) (
  input  logic               clk,
  input  logic               reset,
  sn74ls_dff_bank_if.slave   bus
);

  localparam int   NB      = CHANNELS * WIDTH;
  localparam logic ACT_LVL = (FALLING_EDGE != 0) ? 1'b0 : 1'b1;

  if (CHANNELS < 1 || WIDTH < 1 || SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_param_check
    $error("sn74ls_dff_bank: CHANNELS>=1, WIDTH>=1 and SYNC_STAGES in 0..3 required");
  end

  logic [CHANNELS-1:0] tclk_eff;
  logic [CHANNELS-1:0] prn_eff;
  logic [CHANNELS-1:0] clrn_eff;
  logic [NB-1:0]       d_eff;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign tclk_eff = bus.tclk;
    assign prn_eff  = bus.prn;
    assign clrn_eff = bus.clrn;
    assign d_eff    = bus.d;
  end else begin : g_sync
    logic [CHANNELS-1:0] tclk_sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] tclk_sync_d [SYNC_STAGES];
    logic [CHANNELS-1:0] prn_sync_q  [SYNC_STAGES];
    logic [CHANNELS-1:0] prn_sync_d  [SYNC_STAGES];
    logic [CHANNELS-1:0] clrn_sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] clrn_sync_d [SYNC_STAGES];
    logic [NB-1:0]       d_sync_q    [SYNC_STAGES];
    logic [NB-1:0]       d_sync_d    [SYNC_STAGES];

    // All four pin groups share one shift chain depth so d stays aligned with its tclk.
    always_comb begin
      tclk_sync_d[0] = bus.tclk;
      prn_sync_d[0]  = bus.prn;
      clrn_sync_d[0] = bus.clrn;
      d_sync_d[0]    = bus.d;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        tclk_sync_d[s] = tclk_sync_q[s-1];
        prn_sync_d[s]  = prn_sync_q[s-1];
        clrn_sync_d[s] = clrn_sync_q[s-1];
        d_sync_d[s]    = d_sync_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
          tclk_sync_q[s] <= {CHANNELS{ACT_LVL}};
          prn_sync_q[s]  <= {CHANNELS{1'b1}};
          clrn_sync_q[s] <= {CHANNELS{1'b1}};
          d_sync_q[s]    <= {NB{1'b0}};
        end
      end else begin
        for (int s = 0; s < SYNC_STAGES; s++) begin
          tclk_sync_q[s] <= tclk_sync_d[s];
          prn_sync_q[s]  <= prn_sync_d[s];
          clrn_sync_q[s] <= clrn_sync_d[s];
          d_sync_q[s]    <= d_sync_d[s];
        end
      end
    end

    assign tclk_eff = tclk_sync_q[SYNC_STAGES-1];
    assign prn_eff  = prn_sync_q[SYNC_STAGES-1];
    assign clrn_eff = clrn_sync_q[SYNC_STAGES-1];
    assign d_eff    = d_sync_q[SYNC_STAGES-1];
  end

  logic [CHANNELS-1:0] tprev_q, tprev_d;
  logic [CHANNELS-1:0] cap_q, cap_d;
  logic [NB-1:0]       q_q, q_d;
  logic [NB-1:0]       qn_q, qn_d;
  logic [CHANNELS-1:0] act_edge;
`ifdef SN74LS_DFF_BOTH_ACTIVE_EN
  logic [CHANNELS-1:0] both_q, both_d;
`endif

  assign act_edge = (FALLING_EDGE != 0) ? (~tclk_eff & tprev_q) : (tclk_eff & ~tprev_q);

  // Per-channel priority: clear, preset, pending both-release, active tclk edge, hold.
  always_comb begin
    tprev_d = tclk_eff;
    q_d     = q_q;
    qn_d    = qn_q;
    cap_d   = {CHANNELS{1'b0}};
`ifdef SN74LS_DFF_BOTH_ACTIVE_EN
    both_d  = {CHANNELS{1'b0}};
`endif
    for (int ch = 0; ch < CHANNELS; ch++) begin
`ifdef SN74LS_DFF_BOTH_ACTIVE_EN
      if (!clrn_eff[ch] && !prn_eff[ch]) begin
        q_d[ch*WIDTH +: WIDTH]  = {WIDTH{1'b1}};
        qn_d[ch*WIDTH +: WIDTH] = {WIDTH{1'b1}};
        both_d[ch]              = 1'b1;
      end else if (!clrn_eff[ch]) begin
        q_d[ch*WIDTH +: WIDTH]  = {WIDTH{1'b0}};
        qn_d[ch*WIDTH +: WIDTH] = {WIDTH{1'b1}};
      end else if (!prn_eff[ch]) begin
        q_d[ch*WIDTH +: WIDTH]  = {WIDTH{1'b1}};
        qn_d[ch*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end else if (both_q[ch]) begin
        // Both pins released on the same cycle: silicon settles cleared.
        q_d[ch*WIDTH +: WIDTH]  = {WIDTH{1'b0}};
        qn_d[ch*WIDTH +: WIDTH] = {WIDTH{1'b1}};
      end else if (act_edge[ch]) begin
        q_d[ch*WIDTH +: WIDTH]  = d_eff[ch*WIDTH +: WIDTH];
        qn_d[ch*WIDTH +: WIDTH] = ~d_eff[ch*WIDTH +: WIDTH];
        cap_d[ch]               = 1'b1;
      end else begin
        q_d[ch*WIDTH +: WIDTH]  = q_q[ch*WIDTH +: WIDTH];
        qn_d[ch*WIDTH +: WIDTH] = qn_q[ch*WIDTH +: WIDTH];
      end
`else
      if (!clrn_eff[ch]) begin
        q_d[ch*WIDTH +: WIDTH]  = {WIDTH{1'b0}};
        qn_d[ch*WIDTH +: WIDTH] = {WIDTH{1'b1}};
      end else if (!prn_eff[ch]) begin
        q_d[ch*WIDTH +: WIDTH]  = {WIDTH{1'b1}};
        qn_d[ch*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end else if (act_edge[ch]) begin
        q_d[ch*WIDTH +: WIDTH]  = d_eff[ch*WIDTH +: WIDTH];
        qn_d[ch*WIDTH +: WIDTH] = ~d_eff[ch*WIDTH +: WIDTH];
        cap_d[ch]               = 1'b1;
      end else begin
        q_d[ch*WIDTH +: WIDTH]  = q_q[ch*WIDTH +: WIDTH];
        qn_d[ch*WIDTH +: WIDTH] = qn_q[ch*WIDTH +: WIDTH];
      end
`endif
    end
  end

  // tprev resets to the active level so a tclk held active across reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= {NB{1'b0}};
      qn_q    <= {NB{1'b1}};
      cap_q   <= {CHANNELS{1'b0}};
      tprev_q <= {CHANNELS{ACT_LVL}};
`ifdef SN74LS_DFF_BOTH_ACTIVE_EN
      both_q  <= {CHANNELS{1'b0}};
`endif
    end else begin
      q_q     <= q_d;
      qn_q    <= qn_d;
      cap_q   <= cap_d;
      tprev_q <= tprev_d;
`ifdef SN74LS_DFF_BOTH_ACTIVE_EN
      both_q  <= both_d;
`endif
    end
  end

  assign bus.q   = q_q;
  assign bus.qn  = qn_q;
  assign bus.cap = cap_q;

endmodule

// File: tb/tb_sn74ls_dff_bank.sv
// Directed bench for sn74ls_dff_bank: three instances (rising/no sync, rising/2 sync,
// falling/8-bit/1 sync) checked against a queue of expectations due at given cycles.
module tb_sn74ls_dff_bank;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sn74ls_dff_bank_if #(.CHANNELS(2), .WIDTH(1)) ia ();
  sn74ls_dff_bank_if #(.CHANNELS(2), .WIDTH(1)) ib ();
  sn74ls_dff_bank_if #(.CHANNELS(2), .WIDTH(8)) ic ();

  sn74ls_dff_bank #(.CHANNELS(2), .WIDTH(1), .SYNC_STAGES(0), .FALLING_EDGE(0))
    u_a (.clk(clk), .reset(reset), .bus(ia));
  sn74ls_dff_bank #(.CHANNELS(2), .WIDTH(1), .SYNC_STAGES(2), .FALLING_EDGE(0))
    u_b (.clk(clk), .reset(reset), .bus(ib));
  sn74ls_dff_bank #(.CHANNELS(2), .WIDTH(8), .SYNC_STAGES(1), .FALLING_EDGE(1))
    u_c (.clk(clk), .reset(reset), .bus(ic));

  typedef struct {
    string       tag;
    int          due;
    int          dut;
    logic [15:0] q;
    logic [15:0] qn;
    logic [1:0]  cap;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [33:0] obs(input int dut);
    case (dut)
      0:       return {14'd0, ia.q, 14'd0, ia.qn, ia.cap};
      1:       return {14'd0, ib.q, 14'd0, ib.qn, ib.cap};
      2:       return {ic.q, ic.qn, ic.cap};
      default: return 34'd0;
    endcase
  endfunction

  task automatic want(input int lat, input int dut, input string tag,
                      input logic [15:0] q, input logic [15:0] qn, input logic [1:0] cap);
    exp_t e;
    e.tag = tag; e.due = cyc + lat; e.dut = dut; e.q = q; e.qn = qn; e.cap = cap;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    logic [33:0] o;
    o = obs(e.dut);
    checks++;
    assert (o === {e.q, e.qn, e.cap}) else begin
      failures++;
      $error("FAIL %s (dut %0d cyc %0d): got q=%h qn=%h cap=%b, expected q=%h qn=%h cap=%b",
             e.tag, e.dut, cyc, o[33:18], o[17:2], o[1:0], e.q, e.qn, e.cap);
    end
  endtask

  // Advance to the next falling edge and check every expectation due now.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        compare(sb[i]);
        sb.delete(i);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic       t0, d0, d1, c0;
    logic       exp_q0;

    reset = 1'b1;
    ia.tclk = 2'b11; ia.d = 2'b00; ia.prn = 2'b11; ia.clrn = 2'b11;
    ib.tclk = 2'b11; ib.d = 2'b00; ib.prn = 2'b11; ib.clrn = 2'b11;
    ic.tclk = 2'b00; ic.d = 16'h0000; ic.prn = 2'b11; ic.clrn = 2'b11;
    ticks(3);

    // Reset release with tclk held at the active level: no capture.
    reset = 1'b0;
    for (int l = 0; l < 3; l++) begin
      want(l, 0, "rst_a", 16'h0000, 16'h0003, 2'b00);
      want(l, 1, "rst_b", 16'h0000, 16'h0003, 2'b00);
      want(l, 2, "rst_c", 16'h0000, 16'hFFFF, 2'b00);
    end
    ticks(3);

    // Rising capture on channel 0, direct and through two sync stages.
    ia.tclk = 2'b10; ib.tclk = 2'b10;
    want(1, 0, "drop_a", 16'h0000, 16'h0003, 2'b00);
    ticks(3);
    ia.d = 2'b01; ia.tclk = 2'b11;
    ib.d = 2'b01; ib.tclk = 2'b11;
    want(1, 0, "cap_a",       16'h0001, 16'h0002, 2'b01);
    want(2, 0, "cap_a_hold",  16'h0001, 16'h0002, 2'b00);
    want(2, 1, "cap_b_early", 16'h0000, 16'h0003, 2'b00);
    want(3, 1, "cap_b",       16'h0001, 16'h0002, 2'b01);
    want(4, 1, "cap_b_hold",  16'h0001, 16'h0002, 2'b00);
    ticks(4);

    // Falling edge, 8-bit channel 1 of instance C; a rising edge must not capture.
    ic.tclk = 2'b10;
    want(2, 2, "c_rise_nocap", 16'h0000, 16'hFFFF, 2'b00);
    want(3, 2, "c_rise_nocap2", 16'h0000, 16'hFFFF, 2'b00);
    ticks(3);
    ic.d = 16'hA500; ic.tclk = 2'b00;
    want(1, 2, "c_fall_early", 16'h0000, 16'hFFFF, 2'b00);
    want(2, 2, "c_fall_cap",   16'hA500, 16'h5AFF, 2'b10);
    want(3, 2, "c_fall_hold",  16'hA500, 16'h5AFF, 2'b00);
    ticks(3);
    ic.d = 16'h3C00; ic.tclk = 2'b10;
    want(2, 2, "c_rise_ignored",  16'hA500, 16'h5AFF, 2'b00);
    want(3, 2, "c_rise_ignored2", 16'hA500, 16'h5AFF, 2'b00);
    ticks(3);

    // Clear coincident with a rising edge; edge consumed on release.
    ia.tclk = 2'b10;
    tick();
    ia.clrn = 2'b10; ia.tclk = 2'b11; ia.d = 2'b01;
    want(1, 0, "clr_edge", 16'h0000, 16'h0003, 2'b00);
    tick();
    ia.clrn = 2'b11;
    want(1, 0, "clr_rel",  16'h0000, 16'h0003, 2'b00);
    want(2, 0, "clr_rel2", 16'h0000, 16'h0003, 2'b00);
    ticks(2);
    ia.prn = 2'b10;
    want(1, 0, "preset", 16'h0001, 16'h0002, 2'b00);
    tick();
    ia.prn = 2'b11;
    want(1, 0, "preset_hold", 16'h0001, 16'h0002, 2'b00);
    tick();

    // Clear and preset together.
    ia.clrn = 2'b10; ia.prn = 2'b10;
`ifdef SN74LS_DFF_BOTH_ACTIVE_EN
    want(1, 0, "both", 16'h0001, 16'h0003, 2'b00);
`else
    want(1, 0, "both", 16'h0000, 16'h0003, 2'b00);
`endif
    tick();
    ia.clrn = 2'b11; ia.prn = 2'b11;
    want(1, 0, "both_rel", 16'h0000, 16'h0003, 2'b00);
    tick();
    ia.clrn = 2'b10; ia.prn = 2'b10;
    tick();
    ia.clrn = 2'b11;
    want(1, 0, "clr_first", 16'h0001, 16'h0002, 2'b00);
    tick();
    ia.prn = 2'b11;
    want(1, 0, "prn_last", 16'h0001, 16'h0002, 2'b00);
    tick();

    // Channel 0 toggles every 3 cycles; channel 1 data moves but its tclk is held.
    exp_q0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      t0 = i[0];
      d0 = (i == 1) ? 1'b0 : 1'b1;
      d1 = ~i[0];
      ia.tclk = {1'b1, t0};
      ia.d    = {d1, d0};
      c0 = t0;
      if (t0) exp_q0 = d0;
      want(1, 0, "indep", {15'd0, exp_q0}, {15'd1, ~exp_q0}, {1'b0, c0});
      ticks(3);
    end

    // Mid-sequence reset; capture needs a fresh low-to-high transition afterwards.
    reset = 1'b1;
    want(1, 0, "mid_rst", 16'h0000, 16'h0003, 2'b00);
    ticks(2);
    reset = 1'b0;
    for (int l = 1; l <= 3; l++) want(l, 0, "post_rst_hold", 16'h0000, 16'h0003, 2'b00);
    ticks(3);
    ia.tclk = 2'b10;
    tick();
    ia.tclk = 2'b11;
    want(1, 0, "resume",      16'h0001, 16'h0002, 2'b01);
    want(2, 0, "resume_hold", 16'h0001, 16'h0002, 2'b00);
    ticks(3);

    // Anything still queued was never reached.
    while (sb.size() > 0) begin
      checks++;
      failures++;
      $error("FAIL %s: expectation never checked (due %0d, now %0d)", sb[0].tag, sb[0].due, cyc);
      sb.delete(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
